rename_wide: RTL

RENAME_WIDE -- requirements
Module: rename_wide

---
 rtl/rename_pkg.sv | 25 ++
 rtl/rename_freelist.sv | 71 +++++++
 rtl/rename_wide.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared types and default sizing for the wide register renamer
package rename_pkg;

    localparam int DEF_N_LOG     = 32;
    localparam int DEF_N_PHYS    = 64;
    localparam int DEF_WIDTH     = 2;
    localparam int DEF_COMMIT_W  = 2;
    localparam int DEF_N_CKPT    = 4;
    localparam int DEF_ROB_TAG_W = 6;
    localparam int DEF_P_W       = $clog2(DEF_N_PHYS);
    localparam int DEF_C_W       = $clog2(DEF_N_CKPT);

    typedef logic [DEF_P_W-1:0]       preg_t;
    typedef logic [DEF_C_W-1:0]       ckpt_id_t;
    typedef logic [DEF_ROB_TAG_W-1:0] rob_tag_t;

    // Everything needed to rewind the front end to just after a branch group
    typedef struct packed {
        preg_t [DEF_N_LOG-1:0] map;
        logic  [DEF_P_W:0]     head;
        rob_tag_t              rob_tag;
        logic                  done;
    } ckpt_t;

endpackage

// File: rtl/rename_freelist.sv
// rtl/rename_freelist.sv - circular physical register free list
// Pops from head in lane order, pushes commit frees at tail, head rewinds on mispredict.
module rename_freelist
    import rename_pkg::*;
#(
    parameter int N_LOG    = DEF_N_LOG,
    parameter int N_PHYS   = DEF_N_PHYS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int COMMIT_W = DEF_COMMIT_W,
    localparam int P_W     = $clog2(N_PHYS),
    localparam int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CNT_W-1:0]                 pop_cnt,
    input  logic [COMMIT_W-1:0]              push_valid,
    input  logic [COMMIT_W-1:0][P_W-1:0]     push_preg,
    input  logic                             restore_valid,
    input  logic [P_W:0]                     restore_head,
    output logic [WIDTH-1:0][P_W-1:0]        head_preg,
    output logic [P_W:0]                     head,
    output logic [P_W:0]                     free_cnt
);

    logic [P_W-1:0] mem [N_PHYS];
    logic [P_W:0]   head_q, tail_q, tail_n;
    logic [COMMIT_W-1:0]          push_ok;
    logic [COMMIT_W-1:0][P_W-1:0] push_idx;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            head_preg[k] = mem[head_q[P_W-1:0] + P_W'(k)];
        end
    end

    // p0 backs x0 permanently, so a release of it is dropped
    always_comb begin
        tail_n   = tail_q;
        push_ok  = '0;
        push_idx = '0;
        for (int p = 0; p < COMMIT_W; p++) begin
            push_idx[p] = tail_n[P_W-1:0];
            if (push_valid[p] && push_preg[p] != '0) begin
                push_ok[p] = 1'b1;
                tail_n     = tail_n + (P_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= (P_W+1)'(N_LOG);
            tail_q <= (P_W+1)'(N_PHYS);
            for (int i = 0; i < N_PHYS; i++) begin
                mem[i] <= P_W'(i);
            end
        end else begin
            for (int p = 0; p < COMMIT_W; p++) begin
                if (push_ok[p]) begin
                    mem[push_idx[p]] <= push_preg[p];
                end
            end
            tail_q <= tail_n;
            head_q <= restore_valid ? restore_head : head_q + (P_W+1)'(pop_cnt);
        end
    end

    assign head     = head_q;
    assign free_cnt = tail_q - head_q;

endmodule

// File: rtl/rename_wide.sv
// rtl/rename_wide.sv - multi-lane register renamer with branch checkpoints
// Whole groups are accepted or stalled; results appear one cycle later in a skid-free register stage.
module rename_wide
    import rename_pkg::*;
#(
    parameter int N_LOG     = DEF_N_LOG,
    parameter int N_PHYS    = DEF_N_PHYS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int COMMIT_W  = DEF_COMMIT_W,
    parameter int N_CKPT    = DEF_N_CKPT,
    parameter int ROB_TAG_W = DEF_ROB_TAG_W,
    localparam int P_W      = $clog2(N_PHYS),
    localparam int C_W      = $clog2(N_CKPT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   dec_valid_i,
    input  logic [WIDTH-1:0][4:0]              dec_rs1_i,
    input  logic [WIDTH-1:0][4:0]              dec_rs2_i,
    input  logic [WIDTH-1:0][4:0]              dec_rd_i,
    input  logic [WIDTH-1:0]                   dec_rs1_used_i,
    input  logic [WIDTH-1:0]                   dec_rs2_used_i,
    input  logic [WIDTH-1:0]                   dec_rd_used_i,
    input  logic [WIDTH-1:0]                   dec_is_branch_i,
    output logic                               dec_ready_o,
    output logic [WIDTH-1:0]                   ren_valid_o,
    input  logic                               ren_ready_i,
    output logic [WIDTH-1:0][P_W-1:0]          rs1_p_o,
    output logic [WIDTH-1:0][P_W-1:0]          rs2_p_o,
    output logic [WIDTH-1:0][P_W-1:0]          rd_new_p_o,
    output logic [WIDTH-1:0][P_W-1:0]          rd_old_p_o,
    output logic [WIDTH-1:0][ROB_TAG_W-1:0]    rob_tag_o,
    output logic [WIDTH-1:0][C_W-1:0]          br_tag_o,
    input  logic [COMMIT_W-1:0]                commit_free_valid_i,
    input  logic [COMMIT_W-1:0][P_W-1:0]       commit_free_preg_i,
    input  logic                               br_resolve_valid_i,
    input  logic [C_W-1:0]                     br_resolve_tag_i,
    input  logic                               br_mispredict_i
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [N_LOG-1:0][P_W-1:0]        map_q, map_n;
    logic [ROB_TAG_W-1:0]             rob_q;
    ckpt_t                            ckpt_q [N_CKPT];
    logic [C_W:0]                     ck_head_q, ck_tail_q, ck_cnt, ck_adv;
    logic [C_W-1:0]                   ck_off, ck_idx;
    logic [N_CKPT-1:0]                done_vec;
    logic                             ck_run, res_hit, mis, res_ok;
    logic [WIDTH-1:0]                 lane_en;
    logic [CNT_W-1:0]                 n_acc, n_alloc;
    logic                             has_br, accept;
    logic [WIDTH-1:0][P_W-1:0]        g_rs1, g_rs2, g_new, g_old, fl_preg;
    logic [WIDTH-1:0][ROB_TAG_W-1:0]  g_rob;
    logic [WIDTH-1:0][C_W-1:0]        g_br;
    logic [P_W:0]                     fl_head, fl_cnt;

    // Lanes rename in order against a running copy of the map, which gives the
    // intra-group bypass; the group ends at its first branch.
    always_comb begin
        map_n   = map_q;
        lane_en = '0;
        n_acc   = '0;
        n_alloc = '0;
        has_br  = 1'b0;
        g_rs1   = '0;
        g_rs2   = '0;
        g_new   = '0;
        g_old   = '0;
        g_rob   = '0;
        g_br    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dec_valid_i[i] && !has_br) begin
                lane_en[i] = 1'b1;
                g_rs1[i]   = dec_rs1_used_i[i] ? map_n[dec_rs1_i[i]] : '0;
                g_rs2[i]   = dec_rs2_used_i[i] ? map_n[dec_rs2_i[i]] : '0;
                g_old[i]   = map_n[dec_rd_i[i]];
                g_new[i]   = g_old[i];
                if (dec_rd_used_i[i] && dec_rd_i[i] != 5'd0) begin
                    for (int k = 0; k < WIDTH; k++) begin
                        if (n_alloc == CNT_W'(k)) begin
                            g_new[i] = fl_preg[k];
                        end
                    end
                    map_n[dec_rd_i[i]] = g_new[i];
                    n_alloc            = n_alloc + CNT_W'(1);
                end
                g_rob[i] = rob_q + ROB_TAG_W'(i);
                if (dec_is_branch_i[i]) begin
                    g_br[i] = ck_tail_q[C_W-1:0];
                end
                has_br = has_br | dec_is_branch_i[i];
                n_acc  = n_acc + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ck_cnt  = ck_tail_q - ck_head_q;
        ck_off  = br_resolve_tag_i - ck_head_q[C_W-1:0];
        res_hit = br_resolve_valid_i && ({1'b0, ck_off} < ck_cnt);
        mis     = res_hit && br_mispredict_i;
        res_ok  = res_hit && !br_mispredict_i;
        for (int k = 0; k < N_CKPT; k++) begin
            done_vec[k] = ckpt_q[k].done || (res_ok && br_resolve_tag_i == C_W'(k));
        end
        // Retire the run of resolved checkpoints sitting at the head
        ck_adv = '0;
        ck_run = 1'b1;
        ck_idx = '0;
        for (int k = 0; k < N_CKPT; k++) begin
            ck_idx = ck_head_q[C_W-1:0] + C_W'(k);
            if (ck_run && (C_W+1)'(k) < ck_cnt && done_vec[ck_idx]) begin
                ck_adv = ck_adv + (C_W+1)'(1);
            end else begin
                ck_run = 1'b0;
            end
        end
    end

    assign accept = !rst && (|dec_valid_i) && (!(|ren_valid_o) || ren_ready_i)
                 && ((P_W+1)'(n_alloc) <= fl_cnt)
                 && (!has_br || ck_cnt != (C_W+1)'(N_CKPT))
                 && !(br_resolve_valid_i && br_mispredict_i);
    assign dec_ready_o = accept;

    rename_freelist #(
        .N_LOG    (N_LOG),
        .N_PHYS   (N_PHYS),
        .WIDTH    (WIDTH),
        .COMMIT_W (COMMIT_W)
    ) u_freelist (
        .clk           (clk),
        .rst           (rst),
        .pop_cnt       (accept ? n_alloc : '0),
        .push_valid    (commit_free_valid_i),
        .push_preg     (commit_free_preg_i),
        .restore_valid (mis),
        .restore_head  (ckpt_q[br_resolve_tag_i].head),
        .head_preg     (fl_preg),
        .head          (fl_head),
        .free_cnt      (fl_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_head_q <= '0;
            ck_tail_q <= '0;
            for (int k = 0; k < N_CKPT; k++) begin
                ckpt_q[k] <= '0;
            end
        end else begin
            if (res_ok) begin
                ckpt_q[br_resolve_tag_i].done <= 1'b1;
            end
            if (accept && has_br) begin
                ckpt_q[ck_tail_q[C_W-1:0]] <= '{map:     map_n,
                                               head:    fl_head + (P_W+1)'(n_alloc),
                                               rob_tag: rob_q + ROB_TAG_W'(n_acc),
                                               done:    1'b0};
            end
            if (mis) begin
                ck_tail_q <= ck_head_q + (C_W+1)'(ck_off);
            end else if (accept && has_br) begin
                ck_tail_q <= ck_tail_q + (C_W+1)'(1);
            end
            ck_head_q <= ck_head_q + ck_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LOG; i++) begin
                map_q[i] <= P_W'(i);
            end
            rob_q <= '0;
        end else if (mis) begin
            map_q <= ckpt_q[br_resolve_tag_i].map;
            rob_q <= ckpt_q[br_resolve_tag_i].rob_tag;
        end else if (accept) begin
            map_q <= map_n;
            rob_q <= rob_q + ROB_TAG_W'(n_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ren_valid_o <= '0;
            rs1_p_o     <= '0;
            rs2_p_o     <= '0;
            rd_new_p_o  <= '0;
            rd_old_p_o  <= '0;
            rob_tag_o   <= '0;
            br_tag_o    <= '0;
        end else if (accept) begin
            ren_valid_o <= lane_en;
            rs1_p_o     <= g_rs1;
            rs2_p_o     <= g_rs2;
            rd_new_p_o  <= g_new;
            rd_old_p_o  <= g_old;
            rob_tag_o   <= g_rob;
            br_tag_o    <= g_br;
        end else if (mis || ren_ready_i) begin
            ren_valid_o <= '0;
        end
    end

endmodule
